// File: rtl/mcs4_pkg.sv
// Shared MCS-4 definitions: phase indices, opcode constants used by the CPU
// sequencer and by the RAM/ROM blocks that follow the same 8-phase cycle.
package mcs4_pkg;

    localparam int PH_A1 = 0;
    localparam int PH_A2 = 1;
    localparam int PH_A3 = 2;
    localparam int PH_M1 = 3;
    localparam int PH_M2 = 4;
    localparam int PH_X1 = 5;
    localparam int PH_X2 = 6;
    localparam int PH_X3 = 7;
    localparam int NUM_PHASES = 8;

    localparam logic [3:0] OPR_IO   = 4'hE;
    localparam logic [3:0] OPR_SRC  = 4'h2;
    localparam logic [7:0] INST_DCL = 8'hFD;

    // Even parity over one bus nibble, kept for bus-integrity checkers.
    function automatic logic nibble_parity(input logic [3:0] nib);
        return ^nib;
    endfunction

endpackage

// File: rtl/mcs4_phase_ring.sv
// IDLE / SYNC pre-cycle / one-hot A1..X3 ring of the MCS-4 instruction cycle,
// plus SYNC_N generation. RUN is only looked at in idle and in X3.
module mcs4_phase_ring
    import mcs4_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  run_i,
    output logic [NUM_PHASES-1:0] phase_o,
    output logic                  sync_n_o,
    output logic                  a1_load_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_RING = 2'd2;

    logic [1:0]            st_q;
    logic [1:0]            st_d;
    logic [NUM_PHASES-1:0] ring_q;
    logic [NUM_PHASES-1:0] ring_d;

    // Next state: a lost one-hot token in the ring falls back to idle.
    always_comb begin
        st_d   = st_q;
        ring_d = ring_q;
        case (st_q)
            ST_IDLE: begin
                ring_d = 8'h00;
                if (run_i) begin
                    st_d = ST_SYNC;
                end else begin
                    st_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                st_d   = ST_RING;
                ring_d = 8'h01;
            end
            ST_RING: begin
                if (ring_q[PH_X3]) begin
                    if (run_i) begin
                        ring_d = 8'h01;
                    end else begin
                        st_d   = ST_IDLE;
                        ring_d = 8'h00;
                    end
                end else if (ring_q == 8'h00) begin
                    st_d   = ST_IDLE;
                    ring_d = 8'h00;
                end else begin
                    ring_d = {ring_q[NUM_PHASES-2:0], 1'b0};
                end
            end
            default: begin
                st_d   = ST_IDLE;
                ring_d = 8'h00;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q   <= ST_IDLE;
            ring_q <= 8'h00;
        end else begin
            st_q   <= st_d;
            ring_q <= ring_d;
        end
    end

    // SYNC_N is low in the pre-cycle and in an X3 that chains into A1.
    always_comb begin
        phase_o   = ring_q;
        a1_load_o = ring_d[PH_A1];
        sync_n_o  = ~((st_q == ST_SYNC) |
                      ((st_q == ST_RING) & ring_q[PH_X3] & run_i));
    end

endmodule

// File: rtl/mcs4_bus_sequencer.sv
// CPU-side MCS-4 bus sequencer: drives address/SRC/write nibbles and command
// lines per phase, captures OPR/OPA and I/O read data, holds the DCL bank.
module mcs4_bus_sequencer
    import mcs4_pkg::*;
#(
    parameter int                NUM_BANKS = 8,
    parameter int                BANK_W    = 3,
    parameter logic [BANK_W-1:0] DCL_RESET = '0
) (
    input  logic                  CLK,
    input  logic                  RES,
    input  logic                  RUN,
    input  logic [11:0]           PC,
    input  logic                  SECOND_WORD,
    input  logic [3:0]            ACC,
    input  logic [7:0]            SRC_DATA,
    input  logic [3:0]            DATA_I,
    output logic [3:0]            DATA_O,
    output logic                  DATA_OE,
    output logic                  SYNC_N,
    output logic                  CM_ROM_N,
    output logic [NUM_BANKS-1:0]  CM_N,
    output logic [7:0]            PHASE,
    output logic [7:0]            INST,
    output logic                  INST_VLD,
    output logic [3:0]            RD_DATA,
    output logic                  RD_VLD,
    output logic [BANK_W-1:0]     DCL_BANK
);

    logic [NUM_PHASES-1:0] phase_s;
    logic                  sync_n_s;
    logic                  a1_load_s;

    logic [11:0]       pc_q;
    logic [3:0]        opr_q;
    logic [3:0]        opa_q;
    logic [3:0]        rd_q;
    logic [BANK_W-1:0] bank_q;
    logic [BANK_W-1:0] bank_d;

    logic                 io_s;
    logic                 io_wr_s;
    logic                 io_rd_s;
    logic                 src_s;
    logic                 dcl_s;
    logic [NUM_BANKS-1:0] bank_sel_n_s;

    logic [3:0]           data_o_s;
    logic                 data_oe_s;
    logic                 cm_rom_n_s;
    logic [NUM_BANKS-1:0] cm_n_s;
    logic                 inst_vld_s;
    logic                 rd_vld_s;

    mcs4_phase_ring u_ring (
        .clk_i     (CLK),
        .rst_i     (RES),
        .run_i     (RUN),
        .phase_o   (phase_s),
        .sync_n_o  (sync_n_s),
        .a1_load_o (a1_load_s)
    );

    // Instruction class decode; a second instruction word is always a plain fetch.
    always_comb begin
        io_s    = (opr_q == OPR_IO) & ~SECOND_WORD;
        io_wr_s = io_s & ~opa_q[3];
        io_rd_s = io_s & opa_q[3];
        src_s   = (opr_q == OPR_SRC) & opa_q[0] & ~SECOND_WORD;
        dcl_s   = ({opr_q, opa_q} == INST_DCL) & ~SECOND_WORD;
        bank_sel_n_s         = '1;
        bank_sel_n_s[bank_q] = 1'b0;
        if (phase_s[PH_X3] & dcl_s) begin
            bank_d = ACC[BANK_W-1:0];
        end else begin
            bank_d = bank_q;
        end
    end

    // Per-phase bus and command-line mux; M1/M2/X1 never drive the bus.
    always_comb begin
        data_o_s   = 4'h0;
        data_oe_s  = 1'b0;
        cm_rom_n_s = 1'b1;
        cm_n_s     = '1;
        inst_vld_s = 1'b0;
        rd_vld_s   = 1'b0;
        if (phase_s[PH_A1]) begin
            data_o_s  = pc_q[3:0];
            data_oe_s = 1'b1;
        end else if (phase_s[PH_A2]) begin
            data_o_s  = pc_q[7:4];
            data_oe_s = 1'b1;
        end else if (phase_s[PH_A3]) begin
            data_o_s   = pc_q[11:8];
            data_oe_s  = 1'b1;
            cm_rom_n_s = 1'b0;
        end else if (phase_s[PH_M2] & io_s) begin
            cm_rom_n_s = 1'b0;
            cm_n_s     = bank_sel_n_s;
        end else if (phase_s[PH_X1]) begin
            inst_vld_s = 1'b1;
        end else if (phase_s[PH_X2] & src_s) begin
            data_o_s   = SRC_DATA[7:4];
            data_oe_s  = 1'b1;
            cm_rom_n_s = 1'b0;
            cm_n_s     = bank_sel_n_s;
        end else if (phase_s[PH_X2] & io_wr_s) begin
            data_o_s  = ACC;
            data_oe_s = 1'b1;
        end else if (phase_s[PH_X3] & src_s) begin
            data_o_s  = SRC_DATA[3:0];
            data_oe_s = 1'b1;
        end else if (phase_s[PH_X3] & io_rd_s) begin
            rd_vld_s = 1'b1;
        end else begin
            data_o_s  = 4'h0;
            data_oe_s = 1'b0;
        end
    end

    // Latched address, fetched word, read data and DCL bank.
    always_ff @(posedge CLK) begin
        if (RES) begin
            pc_q   <= 12'h000;
            opr_q  <= 4'h0;
            opa_q  <= 4'h0;
            rd_q   <= 4'h0;
            bank_q <= DCL_RESET;
        end else begin
            if (a1_load_s) begin
                pc_q <= PC;
            end
            if (phase_s[PH_M1]) begin
                opr_q <= DATA_I;
            end
            if (phase_s[PH_M2]) begin
                opa_q <= DATA_I;
            end
            if (phase_s[PH_X2] & io_rd_s) begin
                rd_q <= DATA_I;
            end
            bank_q <= bank_d;
        end
    end

    assign DATA_O   = data_o_s;
    assign DATA_OE  = data_oe_s;
    assign SYNC_N   = sync_n_s;
    assign CM_ROM_N = cm_rom_n_s;
    assign CM_N     = cm_n_s;
    assign PHASE    = phase_s;
    assign INST     = {opr_q, opa_q};
    assign INST_VLD = inst_vld_s;
    assign RD_DATA  = rd_q;
    assign RD_VLD   = rd_vld_s;
    assign DCL_BANK = bank_q;

endmodule
